// File: rtl/bsc_tristate_pkg.sv
// bsc_tristate_pkg
//   Shared types for the half-duplex pad controller: the direction FSM state
//   type and a helper that sizes the turnaround counter.
package bsc_tristate_pkg;

  typedef enum logic [1:0] {
    HIZ      = 2'd0,
    TO_DRIVE = 2'd1,
    DRIVE    = 2'd2,
    TO_HIZ   = 2'd3
  } tristate_state_t;

  // Counter must hold the value TURN; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned turn);
    return (turn < 1) ? 1 : $clog2(turn + 1);
  endfunction

endpackage

// File: rtl/bsc_sync_chain.sv
// bsc_sync_chain
//   Flop chain used to bring an asynchronous bus into the clk domain.
//   Ports:
//     clk     in   1      sampling clock
//     resetn  in   1      asynchronous active-low reset, clears every stage to 0
//     d       in   WIDTH  asynchronous input
//     q       out  WIDTH  value of d delayed STAGES edges
module bsc_sync_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/bsc_tristate_ctrl.sv
// bsc_tristate_ctrl
//   Half-duplex pad controller sitting directly upstream of the pad tristate
//   cell. Turns valid/ready write and read requests into pad drive and pad
//   sample cycles, inserts turnaround cycles on every direction change so the
//   core and the external driver never contend, and synchronises the pad value
//   before returning it as a read response.
//   Ports:
//     clk        in   1      single clock, rising edge
//     resetn     in   1      asynchronous active-low reset
//     wr_valid   in   1      write request
//     wr_ready   out  1      write accepted when wr_valid && wr_ready
//     wr_data    in   WIDTH  value to drive on the pad
//     rd_valid   in   1      read request
//     rd_ready   out  1      read accepted when rd_valid && rd_ready
//     rsp_valid  out  1      one-cycle pulse per accepted read
//     rsp_data   out  WIDTH  sampled pad value, meaningful with rsp_valid
//     pad_in     out  WIDTH  value the tristate cell drives onto the pad
//     pad_oe     out  1      tristate output enable
//     pad_out    in   WIDTH  pad value seen by the tristate cell (async)
//     dir_drive  out  1      1 while the controller is in DRIVE
module bsc_tristate_ctrl
  import bsc_tristate_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TURN        = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] pad_in,
  output logic             pad_oe,
  input  logic [WIDTH-1:0] pad_out,
  output logic             dir_drive
);

  localparam int unsigned     CW      = cnt_width(TURN);
  localparam logic [CW-1:0]   CNT_LD  = CW'(TURN);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  tristate_state_t        state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       pad_in_q, pad_in_d;
  logic                   pad_oe_q, pad_oe_d;
  logic [SYNC_STAGES-1:0] tag_q, tag_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]       rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0]       sync_data;
  logic                   wr_fire;
  logic                   rd_fire;

  bsc_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pad_out),
    .q      (sync_data)
  );

  assign wr_ready = (state_q == DRIVE);
  assign rd_ready = (state_q == HIZ);
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_fire  = rd_valid && rd_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HIZ: begin
        // A pending read keeps us here; only a lone write flips direction.
        if (wr_valid && !rd_valid) begin
          state_d = TO_DRIVE;
          cnt_d   = CNT_LD;
        end
      end
      TO_DRIVE: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (rd_valid && !wr_valid) begin
          state_d = TO_HIZ;
          cnt_d   = CNT_LD;
        end
      end
      TO_HIZ: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = HIZ;
        end
      end
    endcase
  end

  always_comb begin
    pad_in_d = wr_fire ? wr_data : pad_in_q;
    // Enable rises one cycle after DRIVE is entered, together with the first
    // accepted write, so a stale pad_in is never put on the pad. It falls on
    // the same edge that leaves DRIVE.
    pad_oe_d = (state_q == DRIVE) && (state_d == DRIVE);
    // The tag walks beside the data chain; its last stage marks the edge at
    // which the synchronised pad value belongs to an accepted read.
    tag_d       = {tag_q[SYNC_STAGES-2:0], rd_fire};
    rsp_valid_d = tag_q[SYNC_STAGES-1];
    rsp_data_d  = tag_q[SYNC_STAGES-1] ? sync_data : rsp_data_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= HIZ;
      cnt_q       <= '0;
      pad_in_q    <= '0;
      pad_oe_q    <= 1'b0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pad_in_q    <= pad_in_d;
      pad_oe_q    <= pad_oe_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign pad_in    = pad_in_q;
  assign pad_oe    = pad_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign dir_drive = (state_q == DRIVE);

endmodule
